// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: hazard/branch/memory requests in, pipeline register controls out
// Ports (from the controller's point of view, slave modport):
//   enable_i, load_use_i, sl_trigger_i, mem_busy_i, branch_taken_i, clr_stats_i : requests
//   PCWrite_o, if_id_write_o, if_id_flush_o, nopMux_select_o,
//   id_ex_write_o, ex_mem_write_o, stall_active_o, stall_count_o                : controls/status
interface pipeline_stall_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable_i;
    logic                 load_use_i;
    logic                 sl_trigger_i;
    logic                 mem_busy_i;
    logic                 branch_taken_i;
    logic                 clr_stats_i;
    logic                 PCWrite_o;
    logic                 if_id_write_o;
    logic                 if_id_flush_o;
    logic                 nopMux_select_o;
    logic                 id_ex_write_o;
    logic                 ex_mem_write_o;
    logic                 stall_active_o;
    logic [CNT_WIDTH-1:0] stall_count_o;
    modport master (
        output enable_i, load_use_i, sl_trigger_i, mem_busy_i, branch_taken_i, clr_stats_i,
        input  PCWrite_o, if_id_write_o, if_id_flush_o, nopMux_select_o,
               id_ex_write_o, ex_mem_write_o, stall_active_o, stall_count_o
    );
    modport slave (
        input  enable_i, load_use_i, sl_trigger_i, mem_busy_i, branch_taken_i, clr_stats_i,
        output PCWrite_o, if_id_write_o, if_id_flush_o, nopMux_select_o,
               id_ex_write_o, ex_mem_write_o, stall_active_o, stall_count_o
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: prioritised stall/flush/bubble sequencer with saturating stall counter
// Ports:
//   clk_i  : clock, state updates on posedge
//   rst_ni : asynchronous active-low reset
//   bus    : pipeline_stall_controller_if.slave (requests in, pipeline controls and stall_count out)
module pipeline_stall_controller #(
    parameter int STORE_STALL_CYCLES = 2,
    parameter int CNT_WIDTH          = 16
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    pipeline_stall_controller_if.slave bus
);
    typedef enum logic {RUN, FIXED_STALL} state_e;
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                 go, stall, pc_write;
    always_comb begin
        go       = bus.enable_i & ~bus.mem_busy_i;
        // a taken branch overrides both the fixed stall and a load-use bubble
        stall    = ~bus.branch_taken_i & ((state_q == FIXED_STALL) | bus.load_use_i);
        pc_write = go & ~stall;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (go) begin
            if (state_q == RUN) begin
                if (bus.sl_trigger_i & ~bus.branch_taken_i) begin
                    state_d = FIXED_STALL;
                    cnt_d   = 4'(STORE_STALL_CYCLES);
                end
            end else if (bus.branch_taken_i || cnt_q == 4'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
        stall_count_d = bus.clr_stats_i ? '0 :
                        (!pc_write && stall_count_q != '1) ? stall_count_q + CNT_WIDTH'(1) :
                        stall_count_q;
    end
    assign bus.PCWrite_o       = pc_write;
    assign bus.if_id_write_o   = pc_write;
    assign bus.if_id_flush_o   = go & bus.branch_taken_i;
    assign bus.nopMux_select_o = go & (bus.branch_taken_i | stall);
    assign bus.id_ex_write_o   = go;
    assign bus.ex_mem_write_o  = go;
    assign bus.stall_active_o  = state_q == FIXED_STALL;
    assign bus.stall_count_o   = stall_count_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vectors for the stall controller, including a 2-bit counter instance
module tb_pipeline_stall_controller;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;
    pipeline_stall_controller_if #(.CNT_WIDTH(16)) bus ();
    pipeline_stall_controller_if #(.CNT_WIDTH(2))  bus2 ();
    pipeline_stall_controller #(.STORE_STALL_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
    pipeline_stall_controller #(.STORE_STALL_CYCLES(2), .CNT_WIDTH(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus2));
    assign bus2.enable_i       = bus.enable_i;
    assign bus2.load_use_i     = bus.load_use_i;
    assign bus2.sl_trigger_i   = bus.sl_trigger_i;
    assign bus2.mem_busy_i     = bus.mem_busy_i;
    assign bus2.branch_taken_i = bus.branch_taken_i;
    assign bus2.clr_stats_i    = bus.clr_stats_i;
    always #5 clk_i = ~clk_i;
    // {PCWrite, if_id_write, if_id_flush, nopMux_select, id_ex_write, ex_mem_write, stall_active}
    localparam logic [6:0] R6        = 7'b1100110;
    localparam logic [6:0] STALL     = 7'b0001111;
    localparam logic [6:0] LU        = 7'b0001110;
    localparam logic [6:0] FRZ_RUN   = 7'b0000000;
    localparam logic [6:0] FRZ_FIXED = 7'b0000001;
    localparam logic [6:0] BR_RUN    = 7'b1111110;
    localparam logic [6:0] BR_FIXED  = 7'b1111111;
    function automatic logic [6:0] outs();
        return {bus.PCWrite_o, bus.if_id_write_o, bus.if_id_flush_o, bus.nopMux_select_o,
                bus.id_ex_write_o, bus.ex_mem_write_o, bus.stall_active_o};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // drive one cycle's inputs shortly after the edge, then let combinational outputs settle
    task automatic apply(input logic en, input logic lu, input logic sl, input logic mb,
                         input logic br, input logic clr);
        @(posedge clk_i);
        #1;
        bus.enable_i       = en;
        bus.load_use_i     = lu;
        bus.sl_trigger_i   = sl;
        bus.mem_busy_i     = mb;
        bus.branch_taken_i = br;
        bus.clr_stats_i    = clr;
        #1;
    endtask
    initial begin
        bus.enable_i = 1'b1; bus.load_use_i = 1'b0; bus.sl_trigger_i = 1'b0;
        bus.mem_busy_i = 1'b0; bus.branch_taken_i = 1'b0; bus.clr_stats_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0, 0);
            check("t1_outs", 32'(outs()), 32'(R6));
            check("t1_count", 32'(bus.stall_count_o), 0);
        end
        check("t1_count2", 32'(bus2.stall_count_o), 0);
        apply(1, 0, 1, 0, 0, 0); check("t2_trig", 32'(outs()), 32'(R6));
        apply(1, 0, 0, 0, 0, 0); check("t2_stall1", 32'(outs()), 32'(STALL));
        apply(1, 0, 0, 0, 0, 0); check("t2_stall2", 32'(outs()), 32'(STALL));
        check("t2_cnt_mid", 32'(bus.stall_count_o), 1);
        apply(1, 0, 0, 0, 0, 0); check("t2_run", 32'(outs()), 32'(R6));
        check("t2_count", 32'(bus.stall_count_o), 2);
        apply(1, 0, 0, 0, 0, 1); check("clr_cyc", 32'(outs()), 32'(R6));
        apply(1, 0, 1, 0, 0, 0); check("t3_trig", 32'(outs()), 32'(R6));
        check("clr_count", 32'(bus.stall_count_o), 0);
        apply(1, 0, 0, 1, 0, 0); check("t3_frz1", 32'(outs()), 32'(FRZ_FIXED));
        apply(1, 0, 0, 1, 0, 0); check("t3_frz2", 32'(outs()), 32'(FRZ_FIXED));
        apply(1, 0, 0, 1, 0, 0); check("t3_frz3", 32'(outs()), 32'(FRZ_FIXED));
        apply(1, 0, 0, 0, 0, 0); check("t3_stall1", 32'(outs()), 32'(STALL));
        check("t3_cnt_frz", 32'(bus.stall_count_o), 3);
        apply(1, 0, 0, 0, 0, 0); check("t3_stall2", 32'(outs()), 32'(STALL));
        apply(1, 0, 0, 0, 0, 0); check("t3_run", 32'(outs()), 32'(R6));
        check("t3_count", 32'(bus.stall_count_o), 5);
        apply(1, 0, 1, 0, 0, 0); check("t4_trig", 32'(outs()), 32'(R6));
        apply(1, 0, 0, 0, 1, 0); check("t4_branch", 32'(outs()), 32'(BR_FIXED));
        apply(1, 0, 0, 0, 0, 0); check("t4_run", 32'(outs()), 32'(R6));
        check("t4_count", 32'(bus.stall_count_o), 5);
        apply(1, 1, 0, 0, 1, 0); check("t5_lu_br", 32'(outs()), 32'(BR_RUN));
        apply(1, 1, 0, 0, 0, 0); check("t5_lu", 32'(outs()), 32'(LU));
        apply(1, 0, 0, 0, 0, 0); check("t5_lu_run", 32'(outs()), 32'(R6));
        check("t5_count", 32'(bus.stall_count_o), 6);
        apply(1, 0, 1, 0, 1, 0); check("sl_br", 32'(outs()), 32'(BR_RUN));
        apply(1, 0, 0, 0, 0, 0); check("sl_br_run", 32'(outs()), 32'(R6));
        apply(0, 0, 1, 0, 0, 0); check("frz_run", 32'(outs()), 32'(FRZ_RUN));
        apply(1, 0, 0, 0, 0, 0); check("frz_sl_ign", 32'(outs()), 32'(R6));
        check("frz_count", 32'(bus.stall_count_o), 7);
        apply(1, 0, 1, 0, 0, 0); check("sl_fix_trig", 32'(outs()), 32'(R6));
        apply(1, 0, 1, 0, 0, 0); check("sl_fix_s1", 32'(outs()), 32'(STALL));
        apply(1, 0, 0, 0, 0, 0); check("sl_fix_s2", 32'(outs()), 32'(STALL));
        apply(1, 0, 0, 0, 0, 0); check("sl_fix_run", 32'(outs()), 32'(R6));
        check("sl_fix_count", 32'(bus.stall_count_o), 9);
        apply(1, 0, 1, 0, 0, 0); check("t6_trig", 32'(outs()), 32'(R6));
        apply(1, 0, 0, 0, 0, 0); check("t6_stall", 32'(outs()), 32'(STALL));
        rst_ni = 1'b0;
        #1;
        check("t6_rst_outs", 32'(outs()), 32'(R6));
        check("t6_rst_count", 32'(bus.stall_count_o), 0);
        rst_ni = 1'b1;
        apply(1, 0, 0, 0, 0, 0); check("t6_after", 32'(outs()), 32'(R6));
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 0, 0, 0, 0);
            check("sat_lu", 32'(outs()), 32'(LU));
        end
        apply(1, 0, 0, 0, 0, 0);
        check("sat_count16", 32'(bus.stall_count_o), 5);
        check("sat_count2", 32'(bus2.stall_count_o), 3);
        apply(1, 1, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 0);
        check("clr_ovr16", 32'(bus.stall_count_o), 0);
        check("clr_ovr2", 32'(bus2.stall_count_o), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
